led_scan_controller: RTL and testbench
======================================

// Module: led_scan_controller
// PURPOSE
//  Time-multiplexed column scanner that sequences the Conway LED array driver.
//  Steps the column index x through 0..N-1 and gates the driver enable with a blanking gap at every column change.
//  Holds a double-buffered copy of the cell grid: new grids are accepted via a valid/ready handshake,
//  and the displayed copy is swapped only at frame boundaries (no tearing).
//  Sits between the game-of-life core (producer) and the LED array driver (consumer of ena/x/cells).
// PARAMETERS
//  N            5    grid size; legal range 1..8 ($error in initial block otherwise)
//  COL_TICKS    1000 clocks per column with ena high; must be >= 1
//  BLANK_TICKS  16   clocks per column with ena low before drive; must be >= 1
// PORTS
//  clk          in   1               system clock, rising edge
//  rst_n        in   1               asynchronous, active-low reset
//  run          in   1               1 = scan; 0 = park (ena low, x held)
//  cells_in     in   N*N             next grid from producer
//  cells_valid  in   1               producer has a grid on cells_in
//  cells_ready  out  1               controller can accept a grid this cycle
//  ena          out  1               enable to LED array driver
//  x            out  $clog2(N)+1     active column index to driver
//  cells        out  N*N             displayed grid to driver
//  frame_done   out  1               1-cycle pulse when x wraps N-1 -> 0
// BEHAVIOUR
//  Reset (async assert, sync release): state=BLANK, tick=0, x=0, ena=0, cells=0, pending empty,
//   cells_ready=1, frame_done=0. All outputs registered.
//  FSM BLANK: ena=0; tick counts 0..BLANK_TICKS-1; at the last tick -> DRIVE, tick=0.
//  FSM DRIVE: ena=1; tick counts 0..COL_TICKS-1; at the last tick -> BLANK, tick=0,
//   x <= (x==N-1) ? 0 : x+1. ena falls on the same edge x changes, so x never changes while ena=1.
//  Column period = BLANK_TICKS+COL_TICKS; frame period = N*(BLANK_TICKS+COL_TICKS) clocks.
//  frame_done=1 for exactly the cycle following the DRIVE->BLANK edge where x wrapped to 0.
//  Handshake: transfer when cells_valid && cells_ready. cells_ready = !pending_full (registered).
//   Accepted grid -> pending buffer, pending_full=1, cells_ready=0 from next cycle.
//   cells_in may change freely when not transferring; producer holds it only while valid && !ready.
//  Swap: on the wrap edge (DRIVE->BLANK with x==N-1), if pending_full: cells <= pending, pending_full <= 0
//   (ready=1 next cycle).
//   Same-edge case: pending empty and a transfer occurs on the wrap edge -> cells <= cells_in directly;
//   pending stays empty.
//  run=0: next edge forces state=BLANK, ena=0, tick=0, x held, frame_done=0; handshake and pending
//   still operate; no swap while parked.
//   run 0->1: restart BLANK for the current x (full BLANK_TICKS before ena rises).
//  Reset mid-operation: immediate return to reset values; any pending grid is discarded.
//  Counter widths: tick sized for max(COL_TICKS,BLANK_TICKS)-1; x never exceeds N-1.
// TESTING (N=5, COL_TICKS=4, BLANK_TICKS=2, run=1; cycle 0 = first edge after rst_n rises)
//  1 Reset: hold rst_n=0 -> ena=0, x=0, cells=0, cells_ready=1, frame_done=0; asserting rst_n mid-DRIVE
//    drops ena with no clock edge.
//  2 Scan timing: after release -> ena low 2 clk / high 4 clk per column; x steps 0,1,2,3,4,0;
//    frame_done pulses once every 30 clk, the cycle x returns to 0.
//  3 Handshake/swap: push 25'h1FFFFFF mid-frame -> cells_ready=0 next cycle; cells stays 0 until the wrap,
//    then cells=25'h1FFFFFF and ready=1.
//  4 Back-pressure: push A, then hold valid with B -> B not accepted until after the wrap swaps A;
//    B is displayed one frame later; no grid lost.
//  5 Same-edge bypass: pending empty, valid asserted exactly on the wrap edge with 25'h0AAAAAA ->
//    cells=25'h0AAAAAA immediately, ready stays 1.
//  6 Park: drop run during DRIVE at x=2 -> ena=0 next cycle, x stays 2, no frame_done;
//    raise run -> 2 clk blank then ena=1 at x=2.

Source files
------------

// File: rtl/led_scan_controller.sv
// Column scanner for the Conway LED array: steps x with a blanking gap per column
// and double-buffers the displayed grid so it only changes at frame boundaries.
module led_scan_controller #(
  parameter int N           = 5,
  parameter int COL_TICKS   = 1000,
  parameter int BLANK_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [N*N-1:0]       cells_in,
  input  logic                 cells_valid,
  output logic                 cells_ready,
  output logic                 ena,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_done
);

  localparam int MAXT = (COL_TICKS > BLANK_TICKS) ? COL_TICKS : BLANK_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int XW   = $clog2(N) + 1;

  localparam logic [TW-1:0] COL_LAST   = TW'(COL_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

  if (N < 1 || N > 8 || COL_TICKS < 1 || BLANK_TICKS < 1) begin : g_param_err
    $error("led_scan_controller: N must be 1..8, COL_TICKS and BLANK_TICKS >= 1");
  end

  typedef enum logic {BLANK, DRIVE} state_e;

  state_e          state_q;
  logic [TW-1:0]   tick_q;
  logic [XW-1:0]   x_q;
  logic [XW-1:0]   x_d;
  logic            ena_q;
  logic            frame_done_q;
  logic [N*N-1:0]  cells_q;
  logic [N*N-1:0]  pend_q;
  logic            pend_full_q;
  logic            ready_q;
  logic            xfer;
  logic            col_end;
  logic            wrap;

  assign xfer    = cells_valid && ready_q;
  assign col_end = run && (state_q == DRIVE) && (tick_q == COL_LAST);
  assign wrap    = col_end && (x_q == X_LAST);
  assign x_d     = (x_q == X_LAST) ? '0 : x_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      tick_q       <= '0;
      x_q          <= '0;
      ena_q        <= 1'b0;
      frame_done_q <= 1'b0;
      cells_q      <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      frame_done_q <= 1'b0;

      // Parking restarts the current column from the top of BLANK.
      if (!run) begin
        state_q <= BLANK;
        ena_q   <= 1'b0;
        tick_q  <= '0;
      end else begin
        case (state_q)
          BLANK: begin
            if (tick_q == BLANK_LAST) begin
              state_q <= DRIVE;
              ena_q   <= 1'b1;
              tick_q  <= '0;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          DRIVE: begin
            if (col_end) begin
              state_q      <= BLANK;
              ena_q        <= 1'b0;
              tick_q       <= '0;
              x_q          <= x_d;
              frame_done_q <= wrap;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          default: begin
            state_q <= BLANK;
            ena_q   <= 1'b0;
            tick_q  <= '0;
          end
        endcase
      end

      // A grid arriving on an empty buffer exactly at the wrap bypasses pending.
      if (wrap && pend_full_q) begin
        cells_q     <= pend_q;
        pend_full_q <= 1'b0;
        ready_q     <= 1'b1;
      end else if (wrap && xfer) begin
        cells_q <= cells_in;
      end else if (xfer) begin
        pend_q      <= cells_in;
        pend_full_q <= 1'b1;
        ready_q     <= 1'b0;
      end
    end
  end

  assign cells_ready = ready_q;
  assign ena         = ena_q;
  assign x           = x_q;
  assign cells       = cells_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with N=5, COL_TICKS=4, BLANK_TICKS=2.
module tb_led_scan_controller;

  localparam int N = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic [N*N-1:0]   cells_in;
  logic             cells_valid;
  logic             cells_ready;
  logic             ena;
  logic [3:0]       x;
  logic [N*N-1:0]   cells;
  logic             frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int e;

  localparam logic [24:0] G_ALL = 25'h1FFFFFF;
  localparam logic [24:0] G_A   = 25'h0123456;
  localparam logic [24:0] G_B   = 25'h1ABCDEF;
  localparam logic [24:0] G_ALT = 25'h0AAAAAA;

  led_scan_controller #(.N(N), .COL_TICKS(4), .BLANK_TICKS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .cells_in   (cells_in),
    .cells_valid(cells_valid),
    .cells_ready(cells_ready),
    .ena        (ena),
    .x          (x),
    .cells      (cells),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Edge numbering restarts so the first edge after release is edge 0.
  task automatic do_reset();
    rst_n       = 1'b0;
    run         = 1'b1;
    cells_valid = 1'b0;
    cells_in    = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ena",   ena, 0);
    check("rst_x",     x, 0);
    check("rst_cells", cells, 0);
    check("rst_ready", cells_ready, 1);
    check("rst_fd",    frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    e = -1;
  endtask

  initial begin
    // Scan timing: 2 blank / 4 drive per column, frame_done every 30 edges.
    do_reset();
    for (int i = 0; i < 62; i++) begin
      tick();
      check("scan_ena", ena, (e >= 1 && ((e - 1) % 6) < 4) ? 1 : 0);
      check("scan_x",   x, ((e + 1) / 6) % 5);
      check("scan_fd",  frame_done, (e >= 29 && ((e - 29) % 30) == 0) ? 1 : 0);
    end
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ena", ena, 0);
    check("async_rst_x",   x, 0);

    // Handshake and swap at the frame wrap.
    do_reset();
    repeat (10) tick();
    cells_in = G_ALL; cells_valid = 1'b1;
    tick();
    check("hs_ready_low", cells_ready, 0);
    check("hs_cells_old", cells, 0);
    cells_valid = 1'b0; cells_in = '0;
    repeat (18) tick();
    check("hs_cells_prewrap", cells, 0);
    check("hs_ready_prewrap", cells_ready, 0);
    tick();
    check("hs_cells_swap", cells, G_ALL);
    check("hs_ready_back", cells_ready, 1);
    check("hs_fd",         frame_done, 1);

    // Back-pressure: B waits until A has been swapped in.
    do_reset();
    repeat (10) tick();
    cells_in = G_A; cells_valid = 1'b1;
    tick();
    check("bp_ready_low", cells_ready, 0);
    cells_in = G_B;
    repeat (19) tick();
    check("bp_cells_a",  cells, G_A);
    check("bp_ready_hi", cells_ready, 1);
    tick();
    check("bp_b_taken",  cells_ready, 0);
    check("bp_cells_a2", cells, G_A);
    cells_valid = 1'b0; cells_in = '0;
    repeat (28) tick();
    check("bp_cells_a3", cells, G_A);
    tick();
    check("bp_cells_b",   cells, G_B);
    check("bp_ready_end", cells_ready, 1);

    // Same-edge bypass with an empty pending buffer.
    do_reset();
    repeat (29) tick();
    check("byp_pre_cells", cells, 0);
    check("byp_pre_ready", cells_ready, 1);
    cells_in = G_ALT; cells_valid = 1'b1;
    tick();
    check("byp_cells", cells, G_ALT);
    check("byp_ready", cells_ready, 1);
    cells_valid = 1'b0; cells_in = '0;
    tick();
    check("byp_ready2", cells_ready, 1);
    check("byp_cells2", cells, G_ALT);

    // Park during DRIVE at x=2, then resume with a full blank.
    do_reset();
    repeat (15) tick();
    check("park_pre_ena", ena, 1);
    check("park_pre_x",   x, 2);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("park_ena", ena, 0);
      check("park_x",   x, 2);
      check("park_fd",  frame_done, 0);
    end
    run = 1'b1;
    tick();
    check("resume_blank", ena, 0);
    tick();
    check("resume_ena", ena, 1);
    check("resume_x",   x, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
